// File: rtl/gfx_arb_pkg.sv
// Shared types for the graphics-ROM arbiter.
// Requester ids and the transaction state encoding.
package gfx_arb_pkg;

    typedef enum logic [1:0] {
        REQ_BG  = 2'd0,
        REQ_FG  = 2'd1,
        REQ_SPR = 2'd2
    } req_id_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/gfx_rom_arbiter_pick.sv
// Combinational winner select for the graphics-ROM arbiter.
// Raster phase decides whether tiles or sprites take precedence.
module gfx_arb_pick
    import gfx_arb_pkg::*;
(
    input  logic       bg_req,
    input  logic       fg_req,
    input  logic       spr_req,
    input  logic       hbl,
    input  logic [1:0] rr_last,
    input  logic       starve_hit,
    output logic       valid,
    output logic [1:0] winner
);

    logic tile_any;

    assign tile_any = bg_req | fg_req;

    always_comb begin
        valid  = bg_req | fg_req | spr_req;
        winner = REQ_BG;
        if (hbl) begin
            if (spr_req)     winner = REQ_SPR;
            else if (bg_req) winner = REQ_BG;
            else             winner = REQ_FG;
        end else if (spr_req && (starve_hit || !tile_any)) begin
            winner = REQ_SPR;
        end else if (bg_req && fg_req) begin
            // alternate away from whichever tile layer went last
            winner = (rr_last == REQ_BG) ? REQ_FG : REQ_BG;
        end else if (fg_req) begin
            winner = REQ_FG;
        end else begin
            winner = REQ_BG;
        end
    end

endmodule

// File: rtl/gfx_rom_arbiter.sv
// Shares the graphics-ROM read port between BG, FG and sprite fetchers.
// One outstanding read at a time, bounded by an ack watchdog.
module gfx_rom_arbiter
    import gfx_arb_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hbl,
    input  logic              vbl,
    input  logic              bg_req,
    input  logic [ADDR_W-1:0] bg_addr,
    input  logic              fg_req,
    input  logic [ADDR_W-1:0] fg_addr,
    input  logic              spr_req,
    input  logic [ADDR_W-1:0] spr_addr,
    output logic              bg_ack,
    output logic              fg_ack,
    output logic              spr_ack,
    output logic [DATA_W-1:0] gfx_data,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic              timeout_err
);

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    localparam logic [7:0] TMO  = 8'(TIMEOUT);

    state_e            state;
    state_e            state_nx;
    logic [1:0]        cur_id;
    logic [1:0]        rr_last;
    logic [3:0]        starve_cnt;
    logic [7:0]        wd_cnt;
    logic              pick_valid;
    logic [1:0]        pick_id;
    logic              grant;
    logic              done;
    logic [ADDR_W-1:0] grant_addr;
    logic              unused_vbl;

    // vertical blank behaves like the active line for priority
    assign unused_vbl = vbl;

    gfx_arb_pick u_pick (
        .bg_req     (bg_req),
        .fg_req     (fg_req),
        .spr_req    (spr_req),
        .hbl        (hbl),
        .rr_last    (rr_last),
        .starve_hit (starve_cnt == SMAX),
        .valid      (pick_valid),
        .winner     (pick_id)
    );

    assign grant = (state == ST_IDLE) && pick_valid;
    assign done  = (state == ST_WAIT) && (rom_ack || wd_cnt == TMO);

    always_comb begin
        grant_addr = bg_addr;
        unique case (pick_id)
            REQ_FG:  grant_addr = fg_addr;
            REQ_SPR: grant_addr = spr_addr;
            default: grant_addr = bg_addr;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (pick_valid) state_nx = ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  if (done) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rom_req = (state == ST_ISSUE) || (state == ST_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_id      <= REQ_BG;
            rr_last     <= REQ_FG;
            starve_cnt  <= '0;
            wd_cnt      <= '0;
            rom_addr    <= '0;
            gfx_data    <= '0;
            bg_ack      <= 1'b0;
            fg_ack      <= 1'b0;
            spr_ack     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            bg_ack  <= 1'b0;
            fg_ack  <= 1'b0;
            spr_ack <= 1'b0;
            if (grant) begin
                cur_id   <= pick_id;
                rom_addr <= grant_addr;
            end
            if (grant && !hbl && pick_id != REQ_SPR) rr_last <= pick_id;
            if (!spr_req) begin
                starve_cnt <= '0;
            end else if (grant) begin
                if (pick_id == REQ_SPR)     starve_cnt <= '0;
                else if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
            end
            if (state == ST_ISSUE)     wd_cnt <= '0;
            else if (state == ST_WAIT) wd_cnt <= wd_cnt + 8'd1;
            // a real ack wins over a watchdog expiry in the same cycle
            if (done) begin
                gfx_data <= rom_ack ? rom_data : '0;
                bg_ack   <= (cur_id == REQ_BG);
                fg_ack   <= (cur_id == REQ_FG);
                spr_ack  <= (cur_id == REQ_SPR);
                if (!rom_ack) timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Self-checking bench for gfx_rom_arbiter: transaction-level model,
// per-cycle compare, directed scenarios and a randomized soak.
module tb_gfx_rom_arbiter;

    localparam int AW   = 24;
    localparam int DW   = 32;
    localparam int SMAX = 4;
    localparam int TMO  = 63;

    logic          clk = 1'b0;
    logic          reset;
    logic          hbl, vbl;
    logic          bg_req, fg_req, spr_req;
    logic [AW-1:0] bg_addr, fg_addr, spr_addr;
    logic          bg_ack, fg_ack, spr_ack;
    logic [DW-1:0] gfx_data;
    logic          rom_req;
    logic [AW-1:0] rom_addr;
    logic          rom_ack;
    logic [DW-1:0] rom_data;
    logic          timeout_err;

    always #5 clk = ~clk;

    gfx_rom_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .hbl(hbl), .vbl(vbl),
        .bg_req(bg_req), .bg_addr(bg_addr),
        .fg_req(fg_req), .fg_addr(fg_addr),
        .spr_req(spr_req), .spr_addr(spr_addr),
        .bg_ack(bg_ack), .fg_ack(fg_ack), .spr_ack(spr_ack),
        .gfx_data(gfx_data), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data),
        .timeout_err(timeout_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit random_mode;
    int rsp_tgt;
    int tgt;

    // model: ids 0=BG 1=FG 2=SPR; m_n = cycles rom_req has been high
    bit            m_busy;
    int            m_n;
    int            m_id;
    int            m_rr;
    int            m_starve;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_err;
    bit [2:0]      m_ack;

    int            log_id[$];
    int            log_cyc[$];
    logic [DW-1:0] log_data[$];

    function automatic void model_reset();
        m_busy = 0; m_n = 0; m_id = 0; m_rr = 1; m_starve = 0;
        m_addr = '0; m_data = '0; m_err = 0; m_ack = '0;
    endfunction

    function automatic void model_finish(logic [DW-1:0] d, bit e);
        m_busy = 0;
        m_ack[m_id] = 1'b1;
        m_data = d;
        if (e) m_err = 1;
    endfunction

    function automatic void model_edge();
        bit [2:0] r;
        int w;
        r = {spr_req, fg_req, bg_req};
        m_ack = '0;
        if (!spr_req) m_starve = 0;
        if (!m_busy) begin
            if (r != 3'b000) begin
                if (hbl)
                    w = r[2] ? 2 : (r[0] ? 0 : 1);
                else if (r[2] && (m_starve == SMAX || r[1:0] == 2'b00))
                    w = 2;
                else if (r[1:0] == 2'b11)
                    w = 1 - m_rr;
                else
                    w = r[0] ? 0 : 1;
                if (w == 2) m_starve = 0;
                else if (spr_req && m_starve < SMAX) m_starve++;
                if (!hbl && w != 2) m_rr = w;
                m_busy = 1; m_n = 1; m_id = w;
                m_addr = (w == 0) ? bg_addr : (w == 1) ? fg_addr : spr_addr;
            end
        end else if (m_n >= 2 && rom_ack) begin
            model_finish(rom_data, 0);
        end else if (m_n == TMO + 2) begin
            model_finish('0, 1);
        end else begin
            m_n++;
        end
    endfunction

    task automatic chk(string nm, longint got, longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic compare();
        checks++;
        if (rom_req !== m_busy || rom_addr !== m_addr ||
            {spr_ack, fg_ack, bg_ack} !== m_ack ||
            gfx_data !== m_data || timeout_err !== m_err) begin
            errors++;
            $display("FAIL cycle %0d outputs: got req=%b addr=%h ack=%b data=%h err=%b expected req=%b addr=%h ack=%b data=%h err=%b",
                     cyc, rom_req, rom_addr, {spr_ack, fg_ack, bg_ack},
                     gfx_data, timeout_err, m_busy, m_addr, m_ack,
                     m_data, m_err);
        end
    endtask

    function automatic int pick_tgt();
        int k;
        k = int'($urandom_range(0, 31));
        if (k == 0) return TMO + 2;
        if (k < 3)  return 1000;
        return int'($urandom_range(2, 7));
    endfunction

    task automatic drive();
        bit [2:0] r;
        r = {spr_req, fg_req, bg_req};
        if (random_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (r[i] && m_ack[i])                             r[i] = 1'b0;
                else if (r[i] && $urandom_range(0, 79) == 0)      r[i] = 1'b0;
                else if (!r[i] && $urandom_range(0, 2) == 0)      r[i] = 1'b1;
            end
            {spr_req, fg_req, bg_req} = r;
            if ($urandom_range(0, 19) == 0) hbl = ~hbl;
            if ($urandom_range(0, 49) == 0) vbl = ~vbl;
        end
        bg_addr  = AW'($urandom);
        fg_addr  = AW'($urandom);
        spr_addr = AW'($urandom);
        rom_data = random_mode ? DW'($urandom) : 32'hCAFE_F00D;
        if (m_busy) begin
            if (m_n == 1) tgt = (rsp_tgt > 0) ? rsp_tgt : pick_tgt();
            rom_ack = (m_n == tgt) ||
                      (random_mode && m_n == 1 && $urandom_range(0, 7) == 0);
        end else begin
            rom_ack = random_mode && $urandom_range(0, 9) == 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge();
        cyc++;
        #1;
        compare();
        if (bg_ack | fg_ack | spr_ack) begin
            log_id.push_back(spr_ack ? 2 : fg_ack ? 1 : 0);
            log_cyc.push_back(cyc);
            log_data.push_back(gfx_data);
        end
        drive();
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        bg_req = 0; fg_req = 0; spr_req = 0; rom_ack = 0;
        #1;
        chk("async_reset_outputs",
            {rom_req, bg_ack, fg_ack, spr_ack, timeout_err}, 0);
        repeat (2) step();
        reset = 1'b0;
        log_id.delete(); log_cyc.delete(); log_data.delete();
    endtask

    task automatic run_until(string nm, int n, int budget);
        int k;
        k = 0;
        while (log_id.size() < n && k < budget) begin
            step();
            k++;
        end
        chk({nm, "_ack_count"}, log_id.size() >= n ? n : log_id.size(), n);
    endtask

    function automatic int lid(int i);
        return (i < log_id.size()) ? log_id[i] : -1;
    endfunction

    function automatic int lcyc(int i);
        return (i < log_cyc.size()) ? log_cyc[i] : -1;
    endfunction

    initial begin
        int start;
        int exp_ids[$];
        reset = 1'b1; hbl = 0; vbl = 0;
        bg_req = 0; fg_req = 0; spr_req = 0;
        bg_addr = '0; fg_addr = '0; spr_addr = '0;
        rom_ack = 0; rom_data = '0;
        random_mode = 0; rsp_tgt = 3; tgt = 0;
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        chk("reset_rom_req", rom_req, 0);
        chk("reset_gfx_data", gfx_data, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_acks", {bg_ack, fg_ack, spr_ack, timeout_err}, 0);

        // tile round-robin, ROM acks 2 cycles after rom_req
        bg_req = 1; fg_req = 1; start = cyc;
        run_until("rr", 4, 60);
        exp_ids = '{0, 1, 0, 1};
        foreach (exp_ids[i]) chk($sformatf("rr_id%0d", i), lid(i), exp_ids[i]);
        chk("rr_first_latency", lcyc(0) - start, 4);
        chk("rr_spacing", lcyc(1) - lcyc(0), 4);

        // sprite starvation guard
        do_reset();
        bg_req = 1; fg_req = 1; spr_req = 1;
        run_until("starve", 7, 100);
        exp_ids = '{0, 1, 0, 1, 2, 0, 1};
        foreach (exp_ids[i]) chk($sformatf("starve_id%0d", i), lid(i), exp_ids[i]);

        // horizontal blank favours sprites
        do_reset();
        hbl = 1; bg_req = 1; fg_req = 1; spr_req = 1;
        run_until("hbl_spr", 3, 60);
        spr_req = 0;
        run_until("hbl_bg", 4, 30);
        exp_ids = '{2, 2, 2, 0};
        foreach (exp_ids[i]) chk($sformatf("hbl_id%0d", i), lid(i), exp_ids[i]);
        hbl = 0;

        // rom_ack on the expiry cycle is a normal completion
        do_reset();
        rsp_tgt = TMO + 2;
        bg_req = 1; start = cyc;
        run_until("edge_ack", 1, 200);
        chk("edge_ack_latency", lcyc(0) - start, TMO + 3);
        chk("edge_ack_data", log_data.size() > 0 ? log_data[0] : 0, 32'hCAFE_F00D);
        chk("edge_ack_err", timeout_err, 0);

        // ROM never acks: watchdog completion
        do_reset();
        rsp_tgt = 1000;
        bg_req = 1; start = cyc;
        run_until("wd", 1, 200);
        chk("wd_latency", lcyc(0) - start, TMO + 3);
        chk("wd_data", log_data.size() > 0 ? log_data[0] : 1, 0);
        chk("wd_err", timeout_err, 1);
        rsp_tgt = 3;
        run_until("wd_after", 2, 40);
        chk("wd_err_sticky", timeout_err, 1);
        chk("wd_after_data", log_data.size() > 1 ? log_data[1] : 0, 32'hCAFE_F00D);

        // reset during WAIT, stale ack afterwards
        do_reset();
        rsp_tgt = 1000;
        bg_req = 1;
        for (int k = 0; k < 20 && !(m_busy && m_n == 4); k++) step();
        chk("mid_wait_rom_req", rom_req, 1);
        do_reset();
        rsp_tgt = 3;
        repeat (3) step();
        rom_ack = 1;
        repeat (4) step();
        chk("stale_no_ack", log_id.size(), 0);
        chk("stale_rom_req", rom_req, 0);
        fg_req = 1; start = cyc;
        run_until("post_reset", 1, 30);
        chk("post_reset_id", lid(0), 1);
        chk("post_reset_latency", lcyc(0) - start, 4);

        // randomized soak against the model
        do_reset();
        random_mode = 1; rsp_tgt = 0;
        repeat (4000) step();
        chk("soak_saw_acks", log_id.size() > 50, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
